// File: rtl/fir_core_param.sv
`default_nettype none
// ============================================================================
// Module   : fir_core_param
// Brief    : Serial-MAC FIR filter, one tap per cycle, run-time coefficients.
// Revision : 1.0  initial release
// ============================================================================

module fir_core_param #(
    parameter int  TAPS   = 8,
    parameter int  DATA_W = 16,
    parameter int  COEF_W = 16,
    parameter int  ACC_W  = 40,
    localparam int AW     = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_dat,
    input  logic              x_vld,
    output logic              x_rdy,
    output logic [ACC_W-1:0]  y_dat,
    output logic              y_vld,
    input  logic              y_rdy,
    input  logic              coef_we,
    input  logic [AW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_dat,
    input  logic              clr,
    output logic              busy
);

    localparam int            PROD_W = DATA_W + COEF_W;
    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [DATA_W-1:0] smp  [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [ACC_W-1:0]         acc;
    logic [AW-1:0]            tap_idx;

    logic                     idle;
    logic                     accept;
    logic                     addr_ok;
    logic                     coef_wr;
    logic signed [PROD_W-1:0] prod;
    logic [ACC_W-1:0]         prod_ext;
    logic [ACC_W-1:0]         sum;

    assign idle    = (state == IDLE);
    assign accept  = idle && x_vld;
    assign coef_wr = idle && coef_we && addr_ok;

    // Only non-power-of-two depths can see an out-of-range address.
    if (TAPS == (1 << AW)) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_part
        assign addr_ok = (32'(coef_addr) < TAPS);
    end

    assign prod     = PROD_W'(coef[tap_idx]) * PROD_W'(smp[tap_idx]);
    assign prod_ext = ACC_W'(prod);
    assign sum      = acc + prod_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_rdy     = 1'b0;
        y_vld     = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                x_rdy = 1'b1;
                if (x_vld) begin
                    state_nxt = MAC;
                end
            end
            MAC: begin
                busy = 1'b1;
                if (tap_idx == LAST) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                busy  = 1'b1;
                y_vld = 1'b1;
                if (y_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            x_rdy = 1'b0;
            y_vld = 1'b0;
            busy  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            y_dat   <= '0;
            tap_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (x_vld) begin
                        acc     <= '0;
                        tap_idx <= '0;
                    end
                end
                MAC: begin
                    acc <= sum;
                    if (tap_idx == LAST) begin
                        y_dat   <= sum;
                        tap_idx <= '0;
                    end else begin
                        tap_idx <= tap_idx + AW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A clear coinciding with an accept still loads the new sample into tap 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                smp[i] <= '0;
            end
        end else if (accept) begin
            smp[0] <= x_dat;
            for (int i = 1; i < TAPS; i++) begin
                smp[i] <= clr ? '0 : smp[i-1];
            end
        end else if (idle && clr) begin
            for (int i = 0; i < TAPS; i++) begin
                smp[i] <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else if (coef_wr) begin
            coef[coef_addr] <= coef_dat;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fir_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_core_param
// Brief    : Self-checking bench for fir_core_param (4-tap and 8-tap/32-bit).
// Revision : 1.0  initial release
// ============================================================================

module tb_fir_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic signed [15:0] x_dat;
    logic               x_vld, x_rdy;
    logic signed [39:0] y_dat;
    logic               y_vld, y_rdy;
    logic               coef_we;
    logic [1:0]         coef_addr;
    logic signed [15:0] coef_dat;
    logic               clr, busy;

    logic [15:0] b_x_dat;
    logic        b_x_vld, b_x_rdy;
    logic [31:0] b_y_dat;
    logic        b_y_vld, b_y_rdy;
    logic        b_coef_we;
    logic [2:0]  b_coef_addr;
    logic [15:0] b_coef_dat;
    logic        b_clr, b_busy;

    fir_core_param #(.TAPS(4), .DATA_W(16), .COEF_W(16), .ACC_W(40)) u_dut4 (
        .clk(clk), .rst(rst),
        .x_dat(x_dat), .x_vld(x_vld), .x_rdy(x_rdy),
        .y_dat(y_dat), .y_vld(y_vld), .y_rdy(y_rdy),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_dat(coef_dat),
        .clr(clr), .busy(busy)
    );

    fir_core_param #(.TAPS(8), .DATA_W(16), .COEF_W(16), .ACC_W(32)) u_dut8 (
        .clk(clk), .rst(rst),
        .x_dat(b_x_dat), .x_vld(b_x_vld), .x_rdy(b_x_rdy),
        .y_dat(b_y_dat), .y_vld(b_y_vld), .y_rdy(b_y_rdy),
        .coef_we(b_coef_we), .coef_addr(b_coef_addr), .coef_dat(b_coef_dat),
        .clr(b_clr), .busy(b_busy)
    );

    typedef struct {
        logic signed [15:0] x;
        logic signed [39:0] y;
    } vec_t;

    vec_t               tbl[$];
    logic signed [39:0] exp_q[$];
    logic [31:0]        exp8_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic signed [15:0] x, input logic signed [39:0] y);
        vec_t v;
        v.x = x;
        v.y = y;
        tbl.push_back(v);
    endtask

    task automatic load_coef(input int c0, input int c1, input int c2, input int c3);
        int cs[4];
        cs[0] = c0; cs[1] = c1; cs[2] = c2; cs[3] = c3;
        for (int i = 0; i < 4; i++) begin
            coef_we   = 1'b1;
            coef_addr = 2'(i);
            coef_dat  = 16'(cs[i]);
            tick();
        end
        coef_we = 1'b0;
    endtask

    // Drives one sample (optionally with a same-cycle coef write / clear); returns just after accept.
    task automatic send(input logic signed [15:0] x, input logic we,
                        input logic [1:0] a, input logic signed [15:0] d, input logic c);
        int n = 0;
        while (!x_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!x_rdy) check("x_rdy_timeout", x_rdy, 1);
        x_dat = x; x_vld = 1'b1;
        coef_we = we; coef_addr = a; coef_dat = d; clr = c;
        tick();
        x_vld = 1'b0; coef_we = 1'b0; clr = 1'b0;
    endtask

    task automatic wait_vld(input string name, output int n);
        n = 0;
        while (!y_vld && n < 40) begin
            tick();
            n++;
        end
        if (!y_vld) check({name, "_timeout"}, y_vld, 1);
    endtask

    task automatic collect(input string name, input int lat_exp);
        int n;
        logic signed [39:0] e;
        wait_vld(name, n);
        e = exp_q.pop_front();
        check({name, "_y"}, y_dat, e);
        if (lat_exp != 0) check({name, "_lat"}, n, lat_exp);
        tick();
    endtask

    task automatic xfer(input string name, input logic signed [15:0] x,
                        input logic signed [39:0] y);
        exp_q.push_back(y);
        send(x, 1'b0, 2'd0, 16'sd0, 1'b0);
        collect(name, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int                 n;
        int                 bad;
        logic signed [39:0] hold;
        logic [63:0]        p;
        logic [31:0]        e8;

        rst = 1'b1; x_vld = 1'b0; x_dat = '0; y_rdy = 1'b1;
        coef_we = 1'b0; coef_addr = '0; coef_dat = '0; clr = 1'b0;
        b_x_vld = 1'b0; b_x_dat = '0; b_y_rdy = 1'b1;
        b_coef_we = 1'b0; b_coef_addr = '0; b_coef_dat = '0; b_clr = 1'b0;

        repeat (2) tick();
        check("rst_x_rdy", x_rdy, 0);
        check("rst_busy", busy, 0);
        check("rst_y_vld", y_vld, 0);
        check("rst_y_dat", y_dat, 0);
        rst = 1'b0;
        tick();
        check("idle_x_rdy", x_rdy, 1);
        check("idle_busy", busy, 0);

        // Impulse then step-with-negatives
        add_vec(1, 1);  add_vec(0, 2);  add_vec(0, 3);  add_vec(0, 4); add_vec(0, 0);
        add_vec(5, 5);  add_vec(5, 0);  add_vec(5, 10); add_vec(5, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0) load_coef(1, 2, 3, 4);
            if (i == 5) load_coef(1, -1, 2, -2);
            exp_q.push_back(tbl[i].y);
            send(tbl[i].x, 1'b0, 2'd0, 16'sd0, 1'b0);
            if (i == 0) check("mac_busy", busy, 1);
            collect($sformatf("vec%0d", i), (i < 5) ? 4 : 0);
        end

        // Backpressure: s = {3,5,5,5}
        y_rdy = 1'b0;
        exp_q.push_back(-40'sd2);
        send(3, 1'b0, 2'd0, 16'sd0, 1'b0);
        wait_vld("bp", n);
        hold  = y_dat;
        x_vld = 1'b1;
        x_dat = 16'sd100;
        bad   = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (y_dat !== hold || x_rdy !== 1'b0 || y_vld !== 1'b1) bad++;
        end
        check("bp_hold", bad, 0);
        check("bp_y", y_dat, exp_q.pop_front());
        x_vld = 1'b0;
        y_rdy = 1'b1;
        tick();
        check("bp_release_x_rdy", x_rdy, 1);
        check("bp_release_y_vld", y_vld, 0);
        xfer("bp_next", 0, -3);

        // Coefficient write during MAC must be ignored
        exp_q.push_back(-40'sd3);
        send(1, 1'b0, 2'd0, 16'sd0, 1'b0);
        coef_we = 1'b1; coef_addr = 2'd0; coef_dat = 16'sd7;
        tick();
        coef_we = 1'b0;
        collect("cg_mid", 0);
        xfer("cg_after", 2, -5);
        // Write in IDLE together with accept applies to that sample
        exp_q.push_back(40'sd7);
        send(1, 1'b1, 2'd0, 16'sd7, 1'b0);
        collect("cg_same", 0);

        // Wrap on the 8-tap, 32-bit accumulator instance
        for (int i = 0; i < 8; i++) begin
            b_coef_we = 1'b1; b_coef_addr = 3'(i); b_coef_dat = 16'h7FFF;
            tick();
        end
        b_coef_we = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            p  = 64'h3FFF_0001 * 64'(i);
            e8 = (i == 8) ? 32'hFFF8_0008 : p[31:0];
            exp8_q.push_back(e8);
            n = 0;
            while (!b_x_rdy && n < 50) begin tick(); n++; end
            b_x_dat = 16'h7FFF; b_x_vld = 1'b1;
            tick();
            b_x_vld = 1'b0;
            n = 0;
            while (!b_y_vld && n < 40) begin tick(); n++; end
            if (!b_y_vld) check("wrap_timeout", b_y_vld, 1);
            check($sformatf("wrap%0d", i), b_y_dat, exp8_q.pop_front());
            tick();
        end

        // Reset during MAC cycle 2 abandons the sample
        send(4, 1'b0, 2'd0, 16'sd0, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("rst_mid_x_rdy", x_rdy, 0);
        check("rst_mid_busy", busy, 0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (y_vld) bad++;
        end
        check("rst_no_y", bad, 0);
        check("rst_idle", x_rdy, 1);
        xfer("rst_coef_zero", 5, 0);

        // Clear behaviour
        clr = 1'b1;
        tick();
        clr = 1'b0;
        load_coef(1, 10, 100, 1000);
        xfer("h1", 1, 1);
        xfer("h2", 2, 12);
        xfer("h3", 3, 123);
        exp_q.push_back(40'sd9);
        send(9, 1'b0, 2'd0, 16'sd0, 1'b1);
        collect("clr_accept", 0);
        exp_q.push_back(40'sd90);
        send(0, 1'b0, 2'd0, 16'sd0, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        collect("clr_mid_mac", 0);
        xfer("clr_after", 0, 900);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
